// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the RV32M multiply/divide unit
package mdu_pkg;

    localparam int XLEN        = 32;
    localparam int ITER        = 32;
    localparam int MDU_LATENCY = ITER + 1;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_divider_core.sv
// rtl/mdu_divider_core.sv - restoring divider on magnitudes, one quotient bit per step
module mdu_divider_core
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo_next,
    output logic [XLEN-1:0] rem_next
);

    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN:0]   trial;
    logic [XLEN:0]   diff;

    // Shift the next dividend bit into the partial remainder; keep the difference only if it fits
    always_comb begin
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        trial = {rem_q, quo_q[XLEN-1]};
        diff  = trial - {1'b0, dvs_q};
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (step) begin
            if (!diff[XLEN]) begin
                rem_d = diff[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = trial[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    // Next values are exported so the parent can finish the result in the same cycle
    assign quo_next = quo_d;
    assign rem_next = rem_d;

    // Divider state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit with registered result
module mul_div_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import mdu_pkg::*;

    localparam int              CW       = $clog2(ITER);
    localparam logic [CW-1:0]   CNT_LAST = CW'(ITER - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state_q, state_d;
    mdu_op_e           op_q, op_d, op_in;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              rem_neg_q, rem_neg_d;

    logic              a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b, special_res;
    logic              div_zero, div_ovf, is_special;
    logic [XLEN:0]     add_sum;
    logic [2*XLEN-1:0] prod_step, prod_fix;
    logic [XLEN-1:0]   quo_next, rem_next, quo_fix, rem_fix, fixed_res;
    logic              div_load, div_step;

    // Decode the incoming op: signedness, magnitudes and the single-cycle special cases
    always_comb begin
        op_in    = mdu_op_e'(funct3);
        a_signed = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                   (op_in == OP_DIV) || (op_in == OP_REM);
        b_signed = (op_in == OP_MUL) || (op_in == OP_MULH) ||
                   (op_in == OP_DIV) || (op_in == OP_REM);
        sign_a   = a_signed & rs1[XLEN-1];
        sign_b   = b_signed & rs2[XLEN-1];
        mag_a    = sign_a ? -rs1 : rs1;
        mag_b    = sign_b ? -rs2 : rs2;
        div_zero = funct3[2] && (rs2 == '0);
        div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) && (rs1 == INT_MIN) && (rs2 == '1);
        is_special  = div_zero || div_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = funct3[1] ? rs1 : '1;
        end else if (div_ovf) begin
            special_res = funct3[1] ? '0 : INT_MIN;
        end
    end

    // One shift-add multiply step plus the sign fix-up applied on the final iteration
    always_comb begin
        add_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_step = {add_sum, prod_q[XLEN-1:1]};
        prod_fix  = neg_q ? -prod_step : prod_step;
        quo_fix   = neg_q ? -quo_next : quo_next;
        rem_fix   = rem_neg_q ? -rem_next : rem_next;
        case (op_q)
            OP_MUL:                      fixed_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fixed_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fixed_res = quo_fix;
            default:                     fixed_res = rem_fix;
        endcase
    end

    // Control: accept starts in IDLE/DONE, iterate in RUN, flush aborts without touching result
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        done_d    = 1'b0;
        result_d  = result_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div_load  = 1'b0;
        div_step  = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    cnt_d    = cnt_q + CW'(1);
                    prod_d   = prod_step;
                    div_step = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        result_d = fixed_res;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    if (start) begin
                        op_d      = op_in;
                        neg_d     = sign_a ^ sign_b;
                        rem_neg_d = sign_a;
                        cnt_d     = '0;
                        if (is_special) begin
                            state_d  = ST_DONE;
                            done_d   = 1'b1;
                            result_d = special_res;
                        end else begin
                            state_d  = ST_RUN;
                            mcand_d  = mag_a;
                            prod_d   = {{XLEN{1'b0}}, mag_b};
                            div_load = 1'b1;
                        end
                    end
                end
            endcase
        end
        busy_d = (state_d == ST_RUN);
    end

    mdu_divider_core u_div (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (div_load),
        .step     (div_step),
        .dividend (mag_a),
        .divisor  (mag_b),
        .quo_next (quo_next),
        .rem_next (rem_next)
    );

    // State, latched op fields, multiply datapath and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MUL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed scoreboard bench for mul_div_unit
module tb_mul_div_unit;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        busy, done;
    logic [31:0] result;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_res = '0;

    typedef struct {
        logic [31:0] res;
        int          lat;
        string       tag;
    } exp_t;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    mul_div_unit dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_raw(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        funct3 = f;
        rs1    = a;
        rs2    = b;
        start  = 1'b1;
        @(posedge CLK);
        #1;
        start  = 1'b0;
        funct3 = 3'($urandom);
        rs1    = $urandom;
        rs2    = $urandom;
    endtask

    task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input int lat);
        exp_t e;
        e.res = res;
        e.lat = lat;
        e.tag = tag;
        sb.push_back(e);
        last_res = res;
        start_raw(f, a, b);
    endtask

    // Counts negedges after the accepting edge until done; optionally pulses start mid-run
    task automatic wait_done(input int pulse_at);
        exp_t e;
        int   lat;
        lat = 0;
        e   = sb[0];
        for (int i = 1; i <= 60; i++) begin
            @(negedge CLK);
            if (i == 1) check({e.tag, "_busy"}, 32'(busy), 32'(e.lat > 1));
            if (done) begin
                lat = i;
                break;
            end
            if (i == pulse_at) begin
                start  = 1'b1;
                funct3 = F_MULHU;
                rs1    = $urandom;
                rs2    = $urandom;
            end
            if (i == pulse_at + 1) start = 1'b0;
        end
        if (lat == 0) begin
            check({e.tag, "_timeout"}, 32'(done), 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_result"}, result, e.res);
            check({e.tag, "_latency"}, 32'(lat), 32'(e.lat));
        end
    endtask

    task automatic no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            if (done) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'h0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        issue("mul_7_m3", F_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        wait_done(0);
        repeat (2) @(negedge CLK);
        issue("mulhu_max", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        wait_done(0);
        repeat (2) @(negedge CLK);
        issue("mulhsu_m1_2", F_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
        wait_done(0);
        repeat (2) @(negedge CLK);
        issue("mulh_min_min", F_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        wait_done(0);
        repeat (2) @(negedge CLK);
        issue("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        wait_done(0);
        repeat (2) @(negedge CLK);
        issue("rem_m7_2_pulse", F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        wait_done(10);
        repeat (2) @(negedge CLK);
        issue("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 33);
        wait_done(0);
        issue("remu_100_7_b2b", F_REMU, 32'd100, 32'd7, 32'd2, 33);
        wait_done(0);
        issue("mul_6_7_b2b", F_MUL, 32'd6, 32'd7, 32'd42, 33);
        wait_done(0);
        repeat (2) @(negedge CLK);

        issue("div_5_0", F_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        wait_done(0);
        repeat (2) @(negedge CLK);
        issue("remu_5_0", F_REMU, 32'd5, 32'd0, 32'd5, 1);
        wait_done(0);
        repeat (2) @(negedge CLK);
        issue("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        wait_done(0);
        issue("rem_ovf_b2b", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        wait_done(0);
        repeat (2) @(negedge CLK);
        issue("mulhu_after_special", F_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h1, 33);
        wait_done(0);
        repeat (2) @(negedge CLK);

        start_raw(F_MUL, 32'd3, 32'd5);
        repeat (4) @(negedge CLK);
        flush = 1'b1;
        @(posedge CLK);
        #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        no_done("flush_no_done", 40);
        check("flush_result_kept", result, last_res);

        funct3 = F_DIV;
        rs1    = 32'd5;
        rs2    = 32'd0;
        start  = 1'b1;
        flush  = 1'b1;
        @(posedge CLK);
        #1;
        start  = 1'b0;
        flush  = 1'b0;
        check("start_flush_busy", 32'(busy), 32'd0);
        no_done("start_flush_no_done", 5);
        check("start_flush_result", result, last_res);

        start_raw(F_DIV, 32'd100, 32'd3);
        repeat (9) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", result, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        no_done("midrst_no_done", 40);

        issue("divu_after_rst", F_DIVU, 32'd1000, 32'd10, 32'd100, 33);
        wait_done(0);
        @(negedge CLK);
        check("done_single_pulse", 32'(done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
